uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, meaning clock cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all logic rising-edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port rx_in  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port rx_ack  input  1  consumer acknowledge of the current byte.
REQ-006 SHALL have port shift_en  output  1  one-cycle pulse at each data-bit centre, driving the enable of an external shift register.
REQ-007 SHALL have port ser_bit  output  1  sampled bit value, valid while shift_en=1.
REQ-008 SHALL have port rx_data  output  8  last received byte, LSB-first assembled.
REQ-009 SHALL have port rx_valid  output  1  byte available; held until acknowledged.
REQ-010 SHALL have ports frame_err, overrun_err, busy  output  1 each  sticky stop-bit error, sticky overrun, frame in progress.

Function
REQ-011 SHALL pass rx_in through a 2-FF synchronizer; all sampling uses the synchronized value rx_s.
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-013 IDLE: on rx_s=0, go to START with the baud counter cleared; busy=1 in every state except IDLE.
REQ-014 START: at baud count CLKS_PER_BIT/2-1 (integer division), sample rx_s; 0 -> DATA with counter cleared, bit index 0; 1 -> IDLE (false start, no outputs change).
REQ-015 DATA: at count CLKS_PER_BIT-1, sample rx_s, pulse shift_en for exactly one cycle with ser_bit=sample, write rx_data[bit index]; after index 7 -> STOP (or PARITY).
REQ-016 Exactly 8 shift_en pulses per accepted frame; none in START, PARITY, STOP or IDLE.
REQ-017 STOP: at count CLKS_PER_BIT-1, sample rx_s; 1 -> set rx_valid next cycle; 0 -> set frame_err, leave rx_valid unchanged; then IDLE in both cases (mid-stop return permits back-to-back frames).
REQ-018 The baud counter SHALL wrap to 0 on every sample point and be width ceil(log2(CLKS_PER_BIT)).
REQ-019 rx_ack=1 while rx_valid=1 SHALL clear rx_valid next cycle; rx_ack with rx_valid=0 is ignored.
REQ-020 A new byte completing while rx_valid=1 and rx_ack=0 SHALL overwrite rx_data, keep rx_valid=1 and set overrun_err.
REQ-021 Simultaneous rx_ack and new completion: rx_valid stays 1, overrun_err not set.
REQ-022 frame_err and overrun_err SHALL clear only on rst.

Reset
REQ-023 rst=1 SHALL force state IDLE, counters 0, rx_data=8'h00, rx_valid=0, shift_en=0, ser_bit=0, all errors 0, busy=0, synchronizer FFs=1.
REQ-024 rst asserted mid-frame SHALL abandon the frame with no rx_valid or error; the next falling edge after release starts a new frame.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: PARITY state between DATA and STOP samples one even-parity bit at CLKS_PER_BIT-1; mismatch sets sticky output parity_err and suppresses rx_valid for that frame.
REQ-026 Macro undefined: no PARITY state, no parity_err port, DATA goes directly to STOP.

Structure
REQ-027 FSM state enum and bit-count constant DATA_BITS=8 SHALL live in shared package uart_pkg.
REQ-028 Baud counter with sample strobe SHALL be sub-module uart_baud_cnt (inputs clk, rst, clear, terminal count; output tick).

Verification (CLKS_PER_BIT=16)
REQ-029 Frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> 8 shift_en pulses 16 cycles apart, ser_bit sequence 1,0,1,0,0,1,0,1, rx_data=8'hA5, rx_valid=1 until rx_ack.
REQ-030 rx_in low for 3 cycles then high -> return to IDLE, no shift_en, rx_valid=0, busy drops.
REQ-031 Frame 0x3C with stop bit 0 -> frame_err=1, rx_valid=0, rx_data=8'h3C.
REQ-032 Back-to-back 0x11 then 0x22 with no rx_ack -> rx_data=8'h22, rx_valid=1, overrun_err=1.
REQ-033 rst pulse during bit 4 of 0xFF, then frame 0x5A -> rx_data=8'h5A, no errors.
REQ-034 UART_RX_PARITY_EN: 0x07 with parity bit 0 -> parity_err=1, rx_valid=0; with parity bit 1 -> rx_valid=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding, frame size
// and the even-parity helper. PARITY state exists only with UART_RX_PARITY_EN.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } uart_state_e;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud counter: counts up from 0 and raises tick when the count equals the
// terminal value; it then wraps to 0. clear holds the count at 0 without ticking.
module uart_baud_cnt #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [W-1:0] term,
  output logic         tick
);

  logic [W-1:0] cnt_r;

  assign tick = !clear && (cnt_r == term);

  // Count register, wrapping on every sample point.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clear || tick) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + W'(1'b1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 8N1 receiver with per-bit shift strobe, held byte
// handshake and sticky frame/overrun errors. UART_RX_PARITY_EN adds even parity.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 rx_ack,
  output logic                 shift_en,
  output logic                 ser_bit,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic [1:0]           sync_r;
  logic                 rx_s;
  uart_state_e          state_r;
  uart_state_e          state_nxt_s;
  logic                 tick_s;
  logic                 cnt_clear_s;
  logic [CNT_W-1:0]     term_s;
  logic [IDX_W-1:0]     bit_idx_r;
  logic                 data_smp_s;
  logic                 stop_ok_s;
  logic                 stop_bad_s;
  logic                 set_valid_s;
  logic                 shift_en_r;
  logic                 ser_bit_r;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r;
  logic                 frame_err_r;
  logic                 overrun_err_r;
  logic                 busy_r;

  assign rx_s = sync_r[1];

  // Two-flop synchronizer for the asynchronous line; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx_in};
    end
  end

  // Start bit is checked at half a bit, every later bit at a full bit.
  assign cnt_clear_s = (state_r == IDLE);
  assign term_s      = (state_r == START) ? HALF_TC : FULL_TC;

  uart_baud_cnt #(
    .W(CNT_W)
  ) u_baud_cnt (
    .clk  (clk),
    .rst  (rst),
    .clear(cnt_clear_s),
    .term (term_s),
    .tick (tick_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_smp_s;
  logic par_bad_r;
  logic parity_err_r;
`endif

  // Next-state logic and sample-point strobes.
  always_comb begin
    state_nxt_s = state_r;
    data_smp_s  = 1'b0;
    stop_ok_s   = 1'b0;
    stop_bad_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_smp_s   = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (!rx_s) state_nxt_s = START;
        else       state_nxt_s = IDLE;
      end
      START: begin
        if (tick_s) begin
          if (!rx_s) state_nxt_s = DATA;
          else       state_nxt_s = IDLE;
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          data_smp_s = 1'b1;
          if (bit_idx_r == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_nxt_s = PARITY;
`else
            state_nxt_s = STOP;
`endif
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_s) begin
          par_smp_s   = 1'b1;
          state_nxt_s = STOP;
        end else begin
          state_nxt_s = PARITY;
        end
      end
`endif
      STOP: begin
        // Leaving at mid-stop lets a back-to-back start bit be caught.
        if (tick_s) begin
          state_nxt_s = IDLE;
          if (rx_s) stop_ok_s  = 1'b1;
          else      stop_bad_s = 1'b1;
        end else begin
          state_nxt_s = STOP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

`ifdef UART_RX_PARITY_EN
  assign set_valid_s = stop_ok_s && !par_bad_r;

  // Per-frame parity verdict and its sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad_r    <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      if (par_smp_s) begin
        par_bad_r <= (rx_s != even_parity(rx_data_r));
        if (rx_s != even_parity(rx_data_r)) parity_err_r <= 1'b1;
      end else if (state_r == START) begin
        par_bad_r <= 1'b0;
      end
    end
  end

  assign parity_err = parity_err_r;
`else
  assign set_valid_s = stop_ok_s;
`endif

  // Registered datapath: shift strobe, byte assembly, handshake and errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_en_r    <= 1'b0;
      ser_bit_r     <= 1'b0;
      rx_data_r     <= '0;
      rx_valid_r    <= 1'b0;
      frame_err_r   <= 1'b0;
      overrun_err_r <= 1'b0;
      busy_r        <= 1'b0;
      bit_idx_r     <= '0;
    end else begin
      shift_en_r <= data_smp_s;
      busy_r     <= (state_nxt_s != IDLE);
      if (data_smp_s) begin
        ser_bit_r            <= rx_s;
        rx_data_r[bit_idx_r] <= rx_s;
      end
      if (state_r != DATA) begin
        bit_idx_r <= '0;
      end else if (data_smp_s) begin
        bit_idx_r <= bit_idx_r + IDX_W'(1'b1);
      end
      // A simultaneous acknowledge consumes the old byte, so no overrun.
      if (set_valid_s) begin
        rx_valid_r <= 1'b1;
        if (rx_valid_r && !rx_ack) overrun_err_r <= 1'b1;
      end else if (rx_valid_r && rx_ack) begin
        rx_valid_r <= 1'b0;
      end
      if (stop_bad_s) frame_err_r <= 1'b1;
    end
  end

  assign shift_en    = shift_en_r;
  assign ser_bit     = ser_bit_r;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign frame_err   = frame_err_r;
  assign overrun_err = overrun_err_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl at 16 clocks per bit: stimulus queues the
// expected serial bits and bytes, a negedge monitor pops and compares them.
module tb_uart_rx_ctrl;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic       rx_ack;
  logic       shift_en;
  logic       ser_bit;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip_v;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_pulse = 0;
  int frame_pulses = 0;
  int pulse_total = 0;
  logic prev_valid = 1'b0;
  logic       exp_bits[$];
  logic [7:0] exp_bytes[$];

  uart_rx_ctrl #(.CLKS_PER_BIT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .rx_ack     (rx_ack),
    .shift_en   (shift_en),
    .ser_bit    (ser_bit),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .busy       (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    rx_in = b;
    repeat (15) @(negedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip_v);
`endif
    drive_bit(stop_b);
  endtask

  // Monitor: compares every shift strobe and every new byte against the queues.
  always @(negedge clk) begin
    cyc++;
    if (shift_en === 1'b1) begin
      pulse_total++;
      if (exp_bits.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_shift_en: got pulse at cycle %0d expected none", cyc);
      end else begin
        chk("ser_bit", {31'd0, ser_bit}, {31'd0, exp_bits.pop_front()});
      end
      if (frame_pulses > 0) chk("shift_spacing", cyc - last_pulse, 16);
      frame_pulses++;
      last_pulse = cyc;
    end
    if (busy !== 1'b1) frame_pulses = 0;
    if (rx_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (exp_bytes.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rx_valid: got byte %0h expected none", rx_data);
      end else begin
        chk("rx_data_at_valid", {24'd0, rx_data}, {24'd0, exp_bytes.pop_front()});
      end
    end
    prev_valid = rx_valid;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    rx_in = 1'b1;
    rx_ack = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_flip_v = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_shift_en", {31'd0, shift_en}, 32'd0);
    chk("rst_ser_bit", {31'd0, ser_bit}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_overrun_err", {31'd0, overrun_err}, 32'd0);
    rst = 1'b0;
    idle(20);

    // Good frame 0xA5, held until acknowledged
    pulse_total = 0;
    exp_bytes.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(20);
    chk("a5_pulses", pulse_total, 32'd8);
    chk("a5_rx_data", {24'd0, rx_data}, 32'h0000_00A5);
    chk("a5_frame_err", {31'd0, frame_err}, 32'd0);
    idle(30);
    chk("a5_valid_held", {31'd0, rx_valid}, 32'd1);
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    chk("a5_valid_cleared", {31'd0, rx_valid}, 32'd0);

    // False start: line low for three cycles only
    pulse_total = 0;
    @(negedge clk);
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("false_start_busy_high", {31'd0, busy}, 32'd1);
    idle(30);
    chk("false_start_busy_low", {31'd0, busy}, 32'd0);
    chk("false_start_pulses", pulse_total, 32'd0);
    chk("false_start_valid", {31'd0, rx_valid}, 32'd0);

    // 0x3C with a bad stop bit
    pulse_total = 0;
    send_frame(8'h3C, 1'b0);
    idle(40);
    chk("3c_pulses", pulse_total, 32'd8);
    chk("3c_frame_err", {31'd0, frame_err}, 32'd1);
    chk("3c_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("3c_rx_data", {24'd0, rx_data}, 32'h0000_003C);

    // Back-to-back 0x11, 0x22 without acknowledge
    exp_bytes.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(20);
    chk("ovr_rx_data", {24'd0, rx_data}, 32'h0000_0022);
    chk("ovr_rx_valid", {31'd0, rx_valid}, 32'd1);
    chk("ovr_overrun_err", {31'd0, overrun_err}, 32'd1);
    chk("ovr_frame_err_sticky", {31'd0, frame_err}, 32'd1);

    // Reset during bit 4 of 0xFF, then a clean 0x5A
    pulse_total = 0;
    for (int i = 0; i < 4; i++) exp_bits.push_back(1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_pulses", pulse_total, 32'd4);
    chk("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("midrst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("midrst_overrun_err", {31'd0, overrun_err}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    idle(40);
    pulse_total = 0;
    exp_bytes.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    idle(20);
    chk("5a_pulses", pulse_total, 32'd8);
    chk("5a_rx_data", {24'd0, rx_data}, 32'h0000_005A);
    chk("5a_rx_valid", {31'd0, rx_valid}, 32'd1);
    chk("5a_frame_err", {31'd0, frame_err}, 32'd0);
    chk("5a_overrun_err", {31'd0, overrun_err}, 32'd0);

`ifdef UART_RX_PARITY_EN
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    par_flip_v = 1'b1;
    send_frame(8'h07, 1'b1);
    idle(20);
    chk("par_bad_parity_err", {31'd0, parity_err}, 32'd1);
    chk("par_bad_rx_valid", {31'd0, rx_valid}, 32'd0);
    par_flip_v = 1'b0;
    exp_bytes.push_back(8'h07);
    send_frame(8'h07, 1'b1);
    idle(20);
    chk("par_good_rx_valid", {31'd0, rx_valid}, 32'd1);
`endif

    idle(10);
    chk("bits_queue_drained", exp_bits.size(), 32'd0);
    chk("bytes_queue_drained", exp_bytes.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
